// File: rtl/triumph_dmem_responder.sv
// triumph_dmem_responder: word-addressed data RAM plus display/tick/counter MMIO block on the core's data port
module triumph_dmem_responder #(
    parameter int          ADDR_WIDTH = 8,
    parameter int          TICK_DIV   = 50_000_000,
    parameter logic [15:0] MMIO_BASE  = 16'hFFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dcache_addr_i,
    input  logic        dcache_write_en_i,
    input  logic [31:0] dcache_wdata_i,
    output logic [31:0] dcache_rdata_o,
    output logic        flag1s_o,
    output logic [31:0] disp_o,
    output logic        access_err_o
);
    localparam int            PW     = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PS_TOP = PW'(TICK_DIV - 1);
    logic [31:0] mem [2**ADDR_WIDTH];
    logic [31:0] disp, sec_cnt, cyc_cnt;
    logic [PW-1:0] prescaler;
    logic tick_pend, tick, aligned, ram_sel, mmio_sel, legal, wr;
    logic [ADDR_WIDTH-1:0] idx;
    logic [15:0] off;
    assign aligned  = dcache_addr_i[1:0] == 2'b00;
    assign ram_sel  = aligned && dcache_addr_i[31:ADDR_WIDTH+2] == '0;
    assign mmio_sel = aligned && dcache_addr_i[31:16] == MMIO_BASE;
    assign idx      = dcache_addr_i[ADDR_WIDTH+1:2];
    assign off      = dcache_addr_i[15:0];
    assign legal    = ram_sel || (mmio_sel && (off == 16'h0 || off == 16'h4 || off == 16'h8));
    assign wr       = dcache_write_en_i && legal && !rst_i;
    assign tick     = prescaler == PS_TOP;
    assign disp_o   = disp;
    assign dcache_rdata_o = ram_sel ? mem[idx] :
                            !mmio_sel ? '0 :
                            off == 16'h0 ? disp :
                            off == 16'h4 ? sec_cnt :
                            off == 16'h8 ? {31'b0, tick_pend} :
                            off == 16'hC ? cyc_cnt : '0;
    always_ff @(posedge clk_i)
        if (wr && ram_sel) mem[idx] <= dcache_wdata_i;
    // Clear beats increment on SEC; set beats clear on STAT
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            disp         <= '0;
            sec_cnt      <= '0;
            cyc_cnt      <= '0;
            prescaler    <= '0;
            tick_pend    <= 1'b0;
            flag1s_o     <= 1'b0;
            access_err_o <= 1'b0;
        end else begin
            prescaler    <= tick ? '0 : prescaler + 1'b1;
            flag1s_o     <= tick;
            access_err_o <= dcache_write_en_i && !legal;
            cyc_cnt      <= cyc_cnt + 32'd1;
            if (wr && mmio_sel && off == 16'h0) disp <= dcache_wdata_i;
            sec_cnt      <= (wr && mmio_sel && off == 16'h4) ? '0 : sec_cnt + 32'(tick);
            tick_pend    <= tick || (tick_pend && !(wr && mmio_sel && off == 16'h8 && dcache_wdata_i[0]));
        end
    end
endmodule

// File: tb/tb_triumph_dmem_responder.sv
// tb_triumph_dmem_responder: table vectors, corner sequences and random traffic against a reference model
module tb_triumph_dmem_responder;
    localparam int TD = 4;
    localparam int AW = 8;
    logic        clk = 0, rst = 1, we = 0;
    logic [31:0] addr = 0, wdata = 0, rdata, disp;
    logic        flag, err;
    int errors = 0, checks = 0;

    triumph_dmem_responder #(.ADDR_WIDTH(AW), .TICK_DIV(TD), .MMIO_BASE(16'hFFFF)) dut (
        .clk_i(clk), .rst_i(rst), .dcache_addr_i(addr), .dcache_write_en_i(we),
        .dcache_wdata_i(wdata), .dcache_rdata_o(rdata), .flag1s_o(flag),
        .disp_o(disp), .access_err_o(err)
    );

    always #5 clk = ~clk;

    logic [31:0] ram_m [int];
    logic [31:0] disp_m, sec_m, cyc_m;
    bit          pend_m, flag_m, err_m, model_ok = 0;
    longint      t_m;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic bit is_ram(input logic [31:0] a);
        return a[1:0] == 2'b00 && a < (32'd1 << (AW + 2));
    endfunction

    function automatic bit legal_w(input logic [31:0] a);
        return is_ram(a) || a == 32'hFFFF_0000 || a == 32'hFFFF_0004 || a == 32'hFFFF_0008;
    endfunction

    function automatic bit mread(input logic [31:0] a, output logic [31:0] v);
        v = 32'h0;
        if (is_ram(a)) begin
            if (!ram_m.exists(int'(a >> 2))) return 0;
            v = ram_m[int'(a >> 2)];
        end else if (a == 32'hFFFF_0000) v = disp_m;
        else if (a == 32'hFFFF_0004) v = sec_m;
        else if (a == 32'hFFFF_0008) v = {31'b0, pend_m};
        else if (a == 32'hFFFF_000C) v = cyc_m;
        return 1;
    endfunction

    task automatic mupdate(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        bit tk;
        if (r) begin
            disp_m = 0; sec_m = 0; cyc_m = 0; pend_m = 0; flag_m = 0; err_m = 0; t_m = 0;
            model_ok = 1;
            return;
        end
        tk = (t_m % TD) == TD - 1;
        err_m = w && !legal_w(a);
        if (w && is_ram(a)) ram_m[int'(a >> 2)] = d;
        if (w && a == 32'hFFFF_0000) disp_m = d;
        sec_m = (w && a == 32'hFFFF_0004) ? 32'h0 : sec_m + (tk ? 32'd1 : 32'd0);
        pend_m = tk ? 1'b1 : (w && a == 32'hFFFF_0008 && d[0]) ? 1'b0 : pend_m;
        cyc_m = cyc_m + 32'd1;
        flag_m = tk;
        t_m++;
    endtask

    task automatic cycle(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic er);
        logic [31:0] ev;
        bit kn;
        @(negedge clk);
        rst = r; we = w; addr = a; wdata = d;
        #1;
        rd = rdata;
        kn = mread(a, ev);
        if (model_ok && kn) chk("rdata", rdata, ev);
        @(posedge clk);
        mupdate(r, w, a, d);
        #1;
        er = err;
        chk("flag1s", {31'b0, flag}, {31'b0, flag_m});
        chk("access_err", {31'b0, err}, {31'b0, err_m});
        chk("disp", disp, disp_m);
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a, d, exp_rd;
        logic        chk_rd, exp_err;
    } vec_t;

    initial begin
        vec_t        tbl [11];
        logic [31:0] rd, ra;
        logic        er;
        tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0};
        tbl[1]  = '{1'b1, 32'h0000_0014, 32'h1234_5678, 32'h0,         1'b0, 1'b0};
        tbl[2]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 32'h0000_0014, 32'h0,         32'h1234_5678, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 32'h0000_0013, 32'h0000_0055, 32'h0,         1'b1, 1'b1};
        tbl[5]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 32'h0001_0000, 32'h7777_7777, 32'h0,         1'b1, 1'b1};
        tbl[7]  = '{1'b0, 32'h0001_0000, 32'h0,         32'h0,         1'b1, 1'b0};
        tbl[8]  = '{1'b1, 32'hFFFF_0000, 32'h0000_00A5, 32'h0,         1'b1, 1'b0};
        tbl[9]  = '{1'b0, 32'hFFFF_0000, 32'h0,         32'h0000_00A5, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 32'hFFFF_000C, 32'h0,         32'h0,         1'b0, 1'b1};

        cycle(1, 0, 0, 0, rd, er);
        cycle(1, 0, 0, 0, rd, er);
        chk("reset_disp", disp, 32'h0);
        chk("reset_flag", {31'b0, flag}, 32'h0);
        chk("reset_err", {31'b0, err}, 32'h0);

        foreach (tbl[i]) begin
            cycle(0, tbl[i].w, tbl[i].a, tbl[i].d, rd, er);
            if (tbl[i].chk_rd) chk($sformatf("vec%0d_rd", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, tbl[i].exp_err});
        end
        cycle(0, 0, 32'hFFFF_000C, 0, rd, er);

        cycle(1, 0, 0, 0, rd, er);
        for (int i = 1; i <= 12; i++) begin
            cycle(0, 0, 0, 0, rd, er);
            chk($sformatf("tick_flag%0d", i), {31'b0, flag}, {31'b0, (i % TD) == 0});
        end
        cycle(0, 0, 32'hFFFF_0004, 0, rd, er);
        chk("tick_sec", rd, 32'd3);
        cycle(0, 0, 32'hFFFF_0008, 0, rd, er);
        chk("tick_stat", rd, 32'd1);

        cycle(1, 0, 0, 0, rd, er);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, rd, er);
        cycle(0, 1, 32'hFFFF_0008, 32'd1, rd, er);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, rd, er);
        cycle(0, 1, 32'hFFFF_0004, 32'h5, rd, er);
        cycle(0, 0, 32'hFFFF_0004, 0, rd, er);
        chk("coll_sec", rd, 32'd0);
        cycle(0, 1, 32'hFFFF_0008, 32'd1, rd, er);
        chk("coll_stat_set", rd, 32'd1);
        cycle(0, 0, 32'hFFFF_0008, 0, rd, er);
        chk("coll_stat_clr", rd, 32'd0);

        cycle(0, 1, 32'hFFFF_0000, 32'h11, rd, er);
        cycle(1, 1, 32'hFFFF_0000, 32'hA5, rd, er);
        chk("rstmid_disp", disp, 32'h0);
        chk("rstmid_flag", {31'b0, flag}, 32'h0);
        cycle(1, 1, 32'h0000_0010, 32'h0BAD_0BAD, rd, er);
        for (int i = 1; i <= TD; i++) begin
            cycle(0, 0, 32'h0000_0010, 0, rd, er);
            chk("rstmid_ram", rd, 32'hDEAD_BEEF);
            chk($sformatf("rstmid_flag%0d", i), {31'b0, flag}, {31'b0, i == TD});
        end

        cycle(0, 1, 32'hFFFF_0000, 32'h0000_1111, rd, er);
        cycle(0, 1, 32'hFFFF_0000, 32'h0000_2222, rd, er);
        chk("disp_old", rd, 32'h0000_1111);
        chk("disp_new", disp, 32'h0000_2222);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0: ra = 32'($urandom_range(0, 15)) << 2;
                1: ra = 32'hFFFF_0000 | (32'($urandom_range(0, 4)) << 2);
                2: ra = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
                3: ra = 32'h0001_0000 + (32'($urandom_range(0, 255)) << 2);
                default: ra = 32'hFFFF_0000 | 32'($urandom_range(0, 65535));
            endcase
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, ra, $urandom, rd, er);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
